// File: rtl/wb_arbiter_pkg.sv
// Shared register-file widths and load-type codes for the write-back path.
package wb_arbiter_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_DATA_WIDTH = 32;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

endpackage

// File: rtl/wb_alu_fifo.sv
// Small synchronous FIFO buffering ALU results ahead of the write-back port.
module wb_alu_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        pop_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: loads win, buffered ALU results are
// guaranteed a slot after STARVE_LIMIT consecutive load wins.
module wb_arbiter #(
  parameter int ALU_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT   = 4,
  parameter int REG_ADDR_WIDTH = wb_arbiter_pkg::REG_ADDR_WIDTH,
  parameter int REG_DATA_WIDTH = wb_arbiter_pkg::REG_DATA_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              alu_valid,
  output logic                              alu_ready,
  input  logic [REG_ADDR_WIDTH-1:0]         alu_rd,
  input  logic [REG_DATA_WIDTH-1:0]         alu_data,
  input  logic                              ld_valid,
  output logic                              ld_ready,
  input  logic [REG_ADDR_WIDTH-1:0]         ld_rd,
  input  logic [2:0]                        ld_funct3,
  input  logic [1:0]                        ld_byte_off,
  input  logic [REG_DATA_WIDTH-1:0]         ld_word,
  output logic                              we,
  output logic [REG_ADDR_WIDTH-1:0]         r_num_write,
  output logic [REG_DATA_WIDTH-1:0]         data_in,
  output logic [$clog2(ALU_FIFO_DEPTH):0]   fifo_count
);
  import wb_arbiter_pkg::*;

  localparam int EW = REG_ADDR_WIDTH + REG_DATA_WIDTH;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  function automatic logic [REG_DATA_WIDTH-1:0] ld_format(
    input logic [2:0]                funct3,
    input logic [1:0]                off,
    input logic [REG_DATA_WIDTH-1:0] word
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = word[16*off[1] +: 16];
    case (funct3)
      LD_LB:   ld_format = {{(REG_DATA_WIDTH-8){b[7]}}, b};
      LD_LBU:  ld_format = {{(REG_DATA_WIDTH-8){1'b0}}, b};
      LD_LH:   ld_format = {{(REG_DATA_WIDTH-16){h[15]}}, h};
      LD_LHU:  ld_format = {{(REG_DATA_WIDTH-16){1'b0}}, h};
      default: ld_format = word;
    endcase
  endfunction

  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      take_ld;
  logic                      take_alu;
  logic [EW-1:0]             head;
  logic [REG_ADDR_WIDTH-1:0] head_rd;
  logic [REG_DATA_WIDTH-1:0] head_data;
  logic [SW-1:0]             starve_cnt;

  wb_alu_fifo #(
    .DEPTH (ALU_FIFO_DEPTH),
    .WIDTH (EW)
  ) u_alu_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (alu_valid && alu_ready),
    .push_data ({alu_rd, alu_data}),
    .pop       (take_alu),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_rd   = head[EW-1 -: REG_ADDR_WIDTH];
  assign head_data = head[REG_DATA_WIDTH-1:0];

  // Readies depend only on registered state, never on a same-cycle pop.
  assign alu_ready = !fifo_full;
  assign ld_ready  = !(starve_cnt == STARVE_MAX && !fifo_empty);
  assign take_ld   = ld_valid && ld_ready;
  assign take_alu  = !take_ld && !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (fifo_empty || take_alu) begin
      starve_cnt <= '0;
    end else if (take_ld && starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // x0 writes still consume their slot but leave the port untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we          <= 1'b0;
      r_num_write <= '0;
      data_in     <= '0;
    end else begin
      we <= 1'b0;
      if (take_ld && ld_rd != '0) begin
        we          <= 1'b1;
        r_num_write <= ld_rd;
        data_in     <= ld_format(ld_funct3, ld_byte_off, ld_word);
      end else if (take_alu && head_rd != '0) begin
        we          <= 1'b1;
        r_num_write <= head_rd;
        data_in     <= head_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a predictor queues expected writes, a monitor checks them.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_byte_off;
  logic [31:0] ld_word;
  logic        we;
  logic [4:0]  r_num_write;
  logic [31:0] data_in;
  logic [1:0]  fifo_count;

  typedef struct { int t; logic [4:0] rd; logic [31:0] data; } exp_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; } alu_t;

  exp_t        exp_q[$];
  alu_t        m_q[$];
  alu_t        alu_src[$];
  int          m_starve = 0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] ld_exp;
  logic        alu_hs = 1'b0;

  wb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rd       (ld_rd),
    .ld_funct3   (ld_funct3),
    .ld_byte_off (ld_byte_off),
    .ld_word     (ld_word),
    .we          (we),
    .r_num_write (r_num_write),
    .data_in     (data_in),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Predictor: reference model of selection, FIFO occupancy and starvation.
  always @(negedge clk) begin
    int   sz;
    logic m_ld_rdy, m_alu_rdy, tl;
    alu_t h;
    if (rst_n) begin
      sz        = m_q.size();
      m_alu_rdy = (sz != 2);
      m_ld_rdy  = !(m_starve == 4 && sz != 0);
      chk("fifo_count", 32'(fifo_count), 32'(sz));
      chk("alu_ready", 32'(alu_ready), 32'(m_alu_rdy));
      chk("ld_ready", 32'(ld_ready), 32'(m_ld_rdy));
      tl = ld_valid && m_ld_rdy;
      if (tl) begin
        if (ld_rd != 5'd0) exp_q.push_back('{cyc + 1, ld_rd, ld_exp});
      end else if (sz != 0) begin
        h = m_q.pop_front();
        if (h.rd != 5'd0) exp_q.push_back('{cyc + 1, h.rd, h.data});
      end
      if (sz == 0 || !tl) m_starve = 0;
      else if (m_starve < 4) m_starve = m_starve + 1;
      if (alu_valid && m_alu_rdy) m_q.push_back('{alu_rd, alu_data});
    end
  end

  // Monitor: every we pulse must match the write predicted for this cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() != 0 && exp_q[0].t < cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL missing_write: got no we, expected rd=%0d data=0x%08h (cycle %0d)",
                 exp_q[0].rd, exp_q[0].data, cyc);
        void'(exp_q.pop_front());
      end
      if (we) begin
        if (exp_q.size() != 0 && exp_q[0].t == cyc) begin
          chk("wr_rd", 32'(r_num_write), 32'(exp_q[0].rd));
          chk("wr_data", data_in, exp_q[0].data);
          void'(exp_q.pop_front());
        end else begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got rd=%0d data=0x%08h, expected no write (cycle %0d)",
                   r_num_write, data_in, cyc);
        end
      end
    end
  end

  always @(negedge rst_n) begin
    exp_q.delete();
    m_q.delete();
    m_starve = 0;
  end

  // ALU source: holds each queued result until the handshake completes.
  always @(negedge clk) alu_hs = alu_valid && alu_ready && rst_n;

  initial begin
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (alu_hs && alu_src.size() != 0) void'(alu_src.pop_front());
      if (alu_src.size() != 0 && rst_n) begin
        alu_valid = 1'b1;
        alu_rd    = alu_src[0].rd;
        alu_data  = alu_src[0].data;
      end else begin
        alu_valid = 1'b0;
      end
    end
  end

  task automatic step(input logic lv, input logic [4:0] lrd, input logic [2:0] f3,
                      input logic [1:0] off, input logic [31:0] word, input logic [31:0] lexp);
    ld_valid    = lv;
    ld_rd       = lrd;
    ld_funct3   = f3;
    ld_byte_off = off;
    ld_word     = word;
    ld_exp      = lexp;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 5'd0, LD_LW, 2'd0, 32'h0, 32'h0);
  endtask

  initial begin
    ld_valid = 1'b1; ld_rd = 5'd9; ld_funct3 = LD_LW; ld_byte_off = 2'd0;
    ld_word = 32'h1234_5678; ld_exp = 32'h1234_5678;
    repeat (3) begin
      @(negedge clk);
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_fifo_count", 32'(fifo_count), 32'd0);
      chk("rst_alu_ready", 32'(alu_ready), 32'd1);
      chk("rst_ld_ready", 32'(ld_ready), 32'd1);
      chk("rst_r_num_write", 32'(r_num_write), 32'd0);
      chk("rst_data_in", data_in, 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 5'd9, LD_LW, 2'd0, 32'h1234_5678, 32'h1234_5678);

    step(1'b1, 5'd5, LD_LB,  2'd3, 32'h80FF_7F01, 32'hFFFF_FF80);
    step(1'b1, 5'd5, LD_LBU, 2'd3, 32'h80FF_7F01, 32'h0000_0080);
    step(1'b1, 5'd5, LD_LH,  2'd2, 32'h80FF_7F01, 32'hFFFF_80FF);
    step(1'b1, 5'd5, LD_LHU, 2'd1, 32'h80FF_7F01, 32'h0000_7F01);
    step(1'b1, 5'd5, LD_LW,  2'd0, 32'h80FF_7F01, 32'h80FF_7F01);
    step(1'b1, 5'd5, LD_LB,  2'd1, 32'h80FF_7F01, 32'h0000_007F);
    step(1'b1, 5'd5, LD_LH,  2'd3, 32'h80FF_7F01, 32'hFFFF_80FF);
    step(1'b1, 5'd5, 3'b011, 2'd2, 32'h80FF_7F01, 32'h80FF_7F01);
    step(1'b1, 5'd0, LD_LW,  2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    idle(2);

    alu_src.push_back('{5'd1, 32'h11});
    alu_src.push_back('{5'd2, 32'h22});
    alu_src.push_back('{5'd3, 32'h33});
    idle(8);

    alu_src.push_back('{5'd7, 32'hAA});
    for (int i = 0; i < 10; i++) step(1'b1, 5'd6, LD_LW, 2'd0, 32'h600 + 32'(i), 32'h600 + 32'(i));
    idle(3);

    alu_src.push_back('{5'd8, 32'hBB});
    alu_src.push_back('{5'd9, 32'hCC});
    alu_src.push_back('{5'd10, 32'hDD});
    for (int i = 0; i < 20; i++) step(1'b1, 5'd11, LD_LHU, 2'd2, 32'hABCD_0000 + 32'(i), 32'h0000_ABCD);
    idle(5);

    alu_src.push_back('{5'd0, 32'h99});
    alu_src.push_back('{5'd4, 32'h44});
    idle(6);

    alu_src.push_back('{5'd12, 32'hC1});
    alu_src.push_back('{5'd13, 32'hC2});
    for (int i = 0; i < 12 && fifo_count != 2'd2; i++)
      step(1'b1, 5'd6, LD_LW, 2'd0, 32'h700 + 32'(i), 32'h700 + 32'(i));
    chk("fill_before_reset", 32'(fifo_count), 32'd2);
    chk("we_before_reset", 32'(we), 32'd1);
    #6;
    rst_n = 1'b0;
    alu_src.delete();
    ld_valid = 1'b0;
    #1;
    chk("async_rst_we", 32'(we), 32'd0);
    chk("async_rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("async_rst_ld_ready", 32'(ld_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(6);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back initiator for the integer register file. It drives the file's write-enable, write-address and write-data inputs.
- Merges two result sources:
  - ALU results, buffered in a small FIFO.
  - Load data from the data-memory interface, byte/half extracted and sign/zero extended.
- Loads have priority; a starvation counter guarantees ALU progress.
- Sits between the execute/memory stages and the register file.

Parameters:
- ALU_FIFO_DEPTH, 2, entries in the ALU result FIFO; power of two, at least 2.
- STARVE_LIMIT, 4, consecutive load wins allowed while the ALU FIFO is non-empty.
- REG_ADDR_WIDTH, 5, register index width (shared define).
- REG_DATA_WIDTH, 32, data width (shared define).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid is also 1.
- alu_rd  in  REG_ADDR_WIDTH  ALU destination register.
- alu_data  in  REG_DATA_WIDTH  ALU result.
- ld_valid  in  1  load data offered.
- ld_ready  out  1  load accepted this cycle when ld_valid is also 1.
- ld_rd  in  REG_ADDR_WIDTH  load destination register.
- ld_funct3  in  3  load type: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- ld_byte_off  in  2  byte offset of the access within the word.
- ld_word  in  REG_DATA_WIDTH  raw aligned memory word.
- we  out  1  register-file write enable.
- r_num_write  out  REG_ADDR_WIDTH  register-file write address.
- data_in  out  REG_DATA_WIDTH  register-file write data.
- fifo_count  out  $clog2(ALU_FIFO_DEPTH)+1  current ALU FIFO occupancy.

Behaviour:
- Reset (async, active-low), all state cleared:
  - we=0, r_num_write=0, data_in=0.
  - FIFO empty; fifo_count=0; starvation counter starve_cnt=0.
  - Hence alu_ready=1 and ld_ready=1 out of reset.
- Reset asserted mid-operation discards all buffered results; no write is issued on the cycle reset is released.
- alu_ready = (fifo_count != ALU_FIFO_DEPTH). It is a function of registered state only; it does not depend on a pop in the same cycle.
- ld_ready = !(starve_cnt == STARVE_LIMIT && fifo_count != 0). It is a function of registered state only.
- Per-cycle selection, evaluated at the rising edge:
  - If ld_valid && ld_ready: LOAD slot. Write the formatted load; no FIFO pop.
  - Else if fifo_count != 0: ALU slot. Pop the FIFO head and write it.
  - Else: idle; we=0 next cycle, r_num_write and data_in hold their previous values.
- FIFO push:
  - A push happens when alu_valid && alu_ready.
  - Push and pop may occur in the same cycle; fifo_count is then unchanged.
  - Read/write pointers wrap modulo ALU_FIFO_DEPTH.
  - An entry pushed at edge E is poppable no earlier than edge E+1.
- Latency:
  - Load accepted at edge E: we=1 in the cycle following E.
  - ALU result into an empty FIFO with no competing load, accepted at E: we=1 in the cycle following E+1.
  - Order among ALU results is FIFO. Ordering between loads and ALU results is not guaranteed; the hazard logic upstream owns that.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, on each LOAD slot taken while fifo_count != 0 (value before the edge).
  - Clears on any ALU slot, and whenever fifo_count == 0.
  - At STARVE_LIMIT, ld_ready drops for exactly the cycle in which the ALU slot is taken.
- x0 destination:
  - A selected entry with rd == 0 consumes its slot, including the pop and counter updates.
  - we stays 0 for it; r_num_write and data_in are not updated.
- Load formatting, registered together with we:
  - LB: sign-extend byte ld_word[8*off +: 8].
  - LBU: zero-extend the same byte.
  - LH: sign-extend half ld_word[16*off[1] +: 16]; off[0] is ignored.
  - LHU: zero-extend the same half.
  - LW, or any undefined funct3: raw ld_word.
- we is a single-cycle pulse per write; back-to-back writes on consecutive cycles are allowed.

Decomposition:
- Shared defines header: REG_ADDR_WIDTH, REG_DATA_WIDTH, and new load-type codes LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU.
- One sub-module: wb_alu_fifo. It is a parameterised synchronous FIFO with push/pop, count, full/empty flags and async active-low reset.
- Load extraction is a combinational function kept inside wb_arbiter.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with ld_valid=1 -> we=0, fifo_count=0, alu_ready=1, ld_ready=1; first write occurs only after release.
- Load formatting: ld_word=0x80FF7F01, rd=5:
  - LB off=3 -> data_in=0xFFFFFF80.
  - LBU off=3 -> 0x00000080.
  - LH off=2 -> 0xFFFF80FF.
  - LHU off=1 -> 0x00007F01.
  - LW -> 0x80FF7F01.
  - Each with we=1 and r_num_write=5.
- ALU fill/drain: ld_valid=0; push rd=1/0x11, 2/0x22, 3/0x33 on consecutive cycles -> third push accepted only after the first pop; writes appear in order 1, 2, 3; fifo_count never exceeds 2.
- Starvation: FIFO holds rd=7/0xAA, ld_valid=1 continuously -> 4 load writes, then ld_ready=0 for one cycle and write rd=7 data 0xAA, then loads resume.
- x0 suppression: ALU rd=0 then rd=4/0x44 -> no we pulse for rd=0; we=1 with r_num_write=4 one cycle later.
- Async reset mid-drain: FIFO has 2 entries, assert rst_n mid-cycle -> we drops immediately, fifo_count=0; no stale write after release.
